// File: rtl/eth_frame_tx_if.sv
// Byte-stream bundle around the Ethernet framer.
// master: framer side; slave: upstream/downstream environment side.
interface eth_frame_tx_if;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;
  logic       IN_LAST;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX_FIRST;
  logic       TX_LAST;

  modport master (
    input  IN_DATA,
    input  IN_VALID,
    input  IN_LAST,
    input  TX_READY,
    output IN_READY,
    output TX_DATA,
    output TX_VALID,
    output TX_FIRST,
    output TX_LAST
  );

  modport slave (
    output IN_DATA,
    output IN_VALID,
    output IN_LAST,
    output TX_READY,
    input  IN_READY,
    input  TX_DATA,
    input  TX_VALID,
    input  TX_FIRST,
    input  TX_LAST
  );
endinterface

// File: rtl/eth_frame_tx.sv
// Ethernet framer: preamble+SFD, body pass-through, zero pad, CRC-32 FCS, IFG.
// Ports: aclk/aresetn, bus (IN_* body in, TX_* wire out), FRAMES_SENT count.
module eth_frame_tx #(
  parameter int unsigned PREAMBLE_BYTES  = 7,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_CYCLES      = 12
) (
  input  logic         aclk,
  input  logic         aresetn,
  eth_frame_tx_if.master bus,
  output logic [15:0]  FRAMES_SENT
);

  localparam logic [15:0] L_PRE  = 16'(PREAMBLE_BYTES);
  localparam logic [16:0] L_MIN  = 17'(MIN_FRAME_BYTES);
  localparam logic [15:0] L_IFGL = 16'(IFG_CYCLES - 1);
  localparam logic [31:0] L_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_BODY,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_body_cnt;
  logic [31:0] r_crc;
  logic [15:0] r_frames;

  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic        w_tx_first;
  logic        w_tx_last;
  logic        w_in_ready;
  logic        w_xfer;
  logic [31:0] w_fcs;
  logic [31:0] w_crc_next;
  logic [16:0] w_body_inc;
  logic [15:0] w_body_sat;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ L_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign w_fcs = ~r_crc;

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    w_tx_first = 1'b0;
    w_tx_last  = 1'b0;
    w_in_ready = 1'b0;
    unique case (r_state)
      S_PRE: begin
        w_tx_valid = 1'b1;
        w_tx_data  = (r_cnt == L_PRE) ? 8'hD5 : 8'h55;
        w_tx_first = (r_cnt == 16'd0);
      end
      S_BODY: begin
        w_tx_valid = bus.IN_VALID;
        w_tx_data  = bus.IN_DATA;
        w_in_ready = bus.TX_READY;
      end
      S_PAD: begin
        w_tx_valid = 1'b1;
      end
      S_FCS: begin
        w_tx_valid = 1'b1;
        w_tx_last  = (r_cnt[1:0] == 2'd3);
        unique case (r_cnt[1:0])
          2'd0:    w_tx_data = w_fcs[7:0];
          2'd1:    w_tx_data = w_fcs[15:8];
          2'd2:    w_tx_data = w_fcs[23:16];
          default: w_tx_data = w_fcs[31:24];
        endcase
      end
      default: ;
    endcase
  end

  assign w_xfer     = w_tx_valid && bus.TX_READY;
  // Body and pad bytes both go through the CRC via the muxed wire byte.
  assign w_crc_next = crc_byte(r_crc, w_tx_data);
  assign w_body_inc = {1'b0, r_body_cnt} + 17'd1;
  assign w_body_sat = (&r_body_cnt) ? 16'hFFFF : w_body_inc[15:0];

  assign bus.TX_VALID = w_tx_valid;
  assign bus.TX_DATA  = w_tx_data;
  assign bus.TX_FIRST = w_tx_first;
  assign bus.TX_LAST  = w_tx_last;
  assign bus.IN_READY = w_in_ready;
  assign FRAMES_SENT  = r_frames;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_body_cnt <= 16'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_frames   <= 16'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.IN_VALID) begin
            r_state <= S_PRE;
            r_cnt   <= 16'd0;
          end
        end
        S_PRE: begin
          if (w_xfer) begin
            if (r_cnt == L_PRE) begin
              r_state    <= S_BODY;
              r_body_cnt <= 16'd0;
              r_crc      <= 32'hFFFFFFFF;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_BODY: begin
          if (w_xfer) begin
            r_crc      <= w_crc_next;
            r_body_cnt <= w_body_sat;
            if (bus.IN_LAST) begin
              r_cnt <= 16'd0;
              // Unsaturated count decides padding; past 0xFFFF never pads.
              if (w_body_inc < L_MIN) r_state <= S_PAD;
              else                    r_state <= S_FCS;
            end
          end
        end
        S_PAD: begin
          if (w_xfer) begin
            r_crc      <= w_crc_next;
            r_body_cnt <= w_body_sat;
            if (w_body_inc == L_MIN) begin
              r_state <= S_FCS;
              r_cnt   <= 16'd0;
            end
          end
        end
        S_FCS: begin
          if (w_xfer) begin
            if (r_cnt[1:0] == 2'd3) begin
              r_state  <= S_IFG;
              r_cnt    <= 16'd0;
              r_frames <= r_frames + 16'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_IFG: begin
          // Gap timer runs on every cycle regardless of TX_READY.
          if (r_cnt == L_IFGL) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
